// File: rtl/time_counter_chain.sv
// rtl/time_counter_chain.sv - msec/sec/min/hour counter cascade with prescaler, run/stop/done FSM, load, set and alarm
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   i_run_toggle        pulse: IDLE<->RUN, DONE->IDLE
//   i_clear             pulse: fields to INIT_*, prescaler 0, IDLE
//   i_mode              0 = count up, 1 = count down
//   i_stop_at_zero      down-count halts at all-zero (timer mode)
//   i_load, i_load_data pulse + packed {hour[23:19], min[18:13], sec[12:7], msec[6:0]}
//   i_set_inc/dec       pulse: +1/-1 on field i_field_sel (0 msec .. 3 hour), no carry
//   i_alarm_en/time     alarm compare on hour/min/sec
//   o_time              packed current time (registered)
//   o_running           state is RUN
//   o_done/alarm/wrap   one-cycle pulses
module time_counter_chain #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_FREQ = 100,
  parameter int MS_MOD    = 100,
  parameter int SEC_MOD   = 60,
  parameter int MIN_MOD   = 60,
  parameter int HOUR_MOD  = 24,
  parameter int INIT_HOUR = 0,
  parameter int INIT_MIN  = 0,
  parameter int INIT_SEC  = 0,
  parameter int INIT_MS   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_run_toggle,
  input  logic        i_clear,
  input  logic        i_mode,
  input  logic        i_stop_at_zero,
  input  logic        i_load,
  input  logic [23:0] i_load_data,
  input  logic        i_set_inc,
  input  logic        i_set_dec,
  input  logic [1:0]  i_field_sel,
  input  logic        i_alarm_en,
  input  logic [23:0] i_alarm_time,
  output logic [23:0] o_time,
  output logic        o_running,
  output logic        o_done,
  output logic        o_alarm,
  output logic        o_wrap
);

  localparam int DIV = CLK_FREQ / TICK_FREQ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] DIV_MAX = PW'(DIV - 1);

  localparam logic [6:0] MS_MAX    = 7'(MS_MOD - 1);
  localparam logic [5:0] SEC_MAX   = 6'(SEC_MOD - 1);
  localparam logic [5:0] MIN_MAX   = 6'(MIN_MOD - 1);
  localparam logic [4:0] HOUR_MAX  = 5'(HOUR_MOD - 1);
  localparam logic [6:0] MS_INIT   = 7'(INIT_MS);
  localparam logic [5:0] SEC_INIT  = 6'(INIT_SEC);
  localparam logic [5:0] MIN_INIT  = 6'(INIT_MIN);
  localparam logic [4:0] HOUR_INIT = 5'(INIT_HOUR);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [6:0]    ms_q, ms_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d, alarm_q, alarm_d, wrap_q, wrap_d;

  // Cascade result for a tick in the current direction
  logic [6:0] ms_step;
  logic [5:0] sec_step, min_step;
  logic [4:0] hour_step;
  logic       ms_last, sec_last, min_last, hour_last;
  logic       hour_wrap, step_zero, cur_zero, alarm_hit, timer_mode;

  // msec of the alarm value plays no part in the compare
  logic unused_alarm_ms;
  assign unused_alarm_ms = ^i_alarm_time[6:0];

  // Single-field step with wrap inside [0, max]
  function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] max,
                                           input logic dn);
    if (dn) return (v == 7'd0) ? max : v - 7'd1;
    else    return (v == max) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [6:0] clamp(input logic [6:0] v, input logic [6:0] max);
    return (v > max) ? max : v;
  endfunction

  always_comb begin
    timer_mode = i_mode & i_stop_at_zero;
    ms_last    = i_mode ? (ms_q == 7'd0)   : (ms_q == MS_MAX);
    sec_last   = i_mode ? (sec_q == 6'd0)  : (sec_q == SEC_MAX);
    min_last   = i_mode ? (min_q == 6'd0)  : (min_q == MIN_MAX);
    hour_last  = i_mode ? (hour_q == 5'd0) : (hour_q == HOUR_MAX);

    ms_step   = wrap_step(ms_q, MS_MAX, i_mode);
    sec_step  = sec_q;
    min_step  = min_q;
    hour_step = hour_q;
    if (ms_last)
      sec_step = 6'(wrap_step({1'b0, sec_q}, {1'b0, SEC_MAX}, i_mode));
    if (ms_last && sec_last)
      min_step = 6'(wrap_step({1'b0, min_q}, {1'b0, MIN_MAX}, i_mode));
    if (ms_last && sec_last && min_last)
      hour_step = 5'(wrap_step({2'b0, hour_q}, {2'b0, HOUR_MAX}, i_mode));

    hour_wrap = ms_last & sec_last & min_last & hour_last;
    step_zero = ({hour_step, min_step, sec_step, ms_step} == 24'd0);
    cur_zero  = ({hour_q, min_q, sec_q, ms_q} == 24'd0);
    alarm_hit = i_alarm_en && ({hour_step, min_step, sec_step} == i_alarm_time[23:7])
                && (ms_step == 7'd0);
  end

  // Next-state / datapath / pulse outputs
  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    alarm_d = 1'b0;
    wrap_d  = 1'b0;

    if (i_clear) begin
      ms_d    = MS_INIT;
      sec_d   = SEC_INIT;
      min_d   = MIN_INIT;
      hour_d  = HOUR_INIT;
      presc_d = '0;
      state_d = ST_IDLE;
    end else if (i_load) begin
      ms_d    = clamp(i_load_data[6:0], MS_MAX);
      sec_d   = 6'(clamp({1'b0, i_load_data[12:7]}, {1'b0, SEC_MAX}));
      min_d   = 6'(clamp({1'b0, i_load_data[18:13]}, {1'b0, MIN_MAX}));
      hour_d  = 5'(clamp({2'b0, i_load_data[23:19]}, {2'b0, HOUR_MAX}));
      presc_d = '0;
      state_d = ST_IDLE;
    end else begin
      if (i_run_toggle)
        state_d = (state_q == ST_IDLE) ? ST_RUN : ST_IDLE;

      if (state_q == ST_RUN) begin
        presc_d = (presc_q == DIV_MAX) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_q == DIV_MAX);
      end

      // Any set request drops a coincident tick; inc and dec together cancel
      if (i_set_inc || i_set_dec) begin
        if (i_set_inc ^ i_set_dec) begin
          case (i_field_sel)
            2'd0: ms_d   = wrap_step(ms_q, MS_MAX, i_set_dec);
            2'd1: sec_d  = 6'(wrap_step({1'b0, sec_q}, {1'b0, SEC_MAX}, i_set_dec));
            2'd2: min_d  = 6'(wrap_step({1'b0, min_q}, {1'b0, MIN_MAX}, i_set_dec));
            default: hour_d = 5'(wrap_step({2'b0, hour_q}, {2'b0, HOUR_MAX}, i_set_dec));
          endcase
        end
      end else if (tick_q && state_q == ST_RUN) begin
        if (timer_mode && cur_zero) begin
          // Started at zero: finish without wrapping
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          ms_d    = ms_step;
          sec_d   = sec_step;
          min_d   = min_step;
          hour_d  = hour_step;
          wrap_d  = hour_wrap;
          alarm_d = alarm_hit;
          if (timer_mode && step_zero) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ms_q    <= MS_INIT;
      sec_q   <= SEC_INIT;
      min_q   <= MIN_INIT;
      hour_q  <= HOUR_INIT;
      presc_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_time    = {hour_q, min_q, sec_q, ms_q};
  assign o_running = (state_q == ST_RUN);
  assign o_done    = done_q;
  assign o_alarm   = alarm_q;
  assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_time_counter_chain.sv
// tb/tb_time_counter_chain.sv - scoreboard bench for time_counter_chain against a total-msec reference model
module tb_time_counter_chain;

  localparam int DIV   = 10;
  localparam int MSM   = 100;
  localparam int SECM  = 60;
  localparam int MINM  = 60;
  localparam int HRM   = 24;
  localparam int TOTAL = MSM * SECM * MINM * HRM;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_run_toggle = 1'b0, i_clear = 1'b0, i_mode = 1'b0, i_stop_at_zero = 1'b0;
  logic        i_load = 1'b0, i_set_inc = 1'b0, i_set_dec = 1'b0, i_alarm_en = 1'b0;
  logic [23:0] i_load_data = '0, i_alarm_time = '0;
  logic [1:0]  i_field_sel = '0;
  logic [23:0] o_time;
  logic        o_running, o_done, o_alarm, o_wrap;

  always #5 clk = ~clk;

  time_counter_chain #(.CLK_FREQ(10), .TICK_FREQ(1)) dut (
    .clk(clk), .reset(reset), .i_run_toggle(i_run_toggle), .i_clear(i_clear),
    .i_mode(i_mode), .i_stop_at_zero(i_stop_at_zero), .i_load(i_load),
    .i_load_data(i_load_data), .i_set_inc(i_set_inc), .i_set_dec(i_set_dec),
    .i_field_sel(i_field_sel), .i_alarm_en(i_alarm_en), .i_alarm_time(i_alarm_time),
    .o_time(o_time), .o_running(o_running), .o_done(o_done), .o_alarm(o_alarm),
    .o_wrap(o_wrap)
  );

  typedef struct packed {
    logic [23:0] t;
    logic        run, done, alarm, wrap;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int n_wrap = 0, n_done = 0, n_alarm = 0;

  // Held-level stimulus shadows, copied onto the pins inside cyc()
  bit          mode_v = 0, stop_v = 0, aen_v = 0;
  logic [23:0] ld_v = '0, atime_v = '0;
  logic [1:0]  sel_v = '0;

  // Reference model: time as a single msec count since 00:00:00.00
  int m_total = 0, m_state = S_IDLE, m_cnt = 0;
  bit m_tick = 0;

  function automatic logic [23:0] pack(input int t);
    int ms, s, mi, h;
    ms = t % MSM;
    s  = (t / MSM) % SECM;
    mi = (t / (MSM * SECM)) % MINM;
    h  = t / (MSM * SECM * MINM);
    return {5'(h), 6'(mi), 6'(s), 7'(ms)};
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int clamp_total(input logic [23:0] d);
    int h, mi, s, ms;
    h  = min_i(int'(d[23:19]), HRM - 1);
    mi = min_i(int'(d[18:13]), MINM - 1);
    s  = min_i(int'(d[12:7]), SECM - 1);
    ms = min_i(int'(d[6:0]), MSM - 1);
    return ((h * MINM + mi) * SECM + s) * MSM + ms;
  endfunction

  function automatic int set_field(input int t, input logic [1:0] sel, input bit up);
    int f[4];
    int m[4];
    f[0] = t % MSM; f[1] = (t / MSM) % SECM;
    f[2] = (t / (MSM * SECM)) % MINM; f[3] = t / (MSM * SECM * MINM);
    m[0] = MSM; m[1] = SECM; m[2] = MINM; m[3] = HRM;
    f[sel] = up ? (f[sel] + 1) % m[sel] : (f[sel] + m[sel] - 1) % m[sel];
    return ((f[3] * MINM + f[2]) * SECM + f[1]) * MSM + f[0];
  endfunction

  function automatic int alarm_total(input logic [23:0] a);
    return ((int'(a[23:19]) * MINM + int'(a[18:13])) * SECM + int'(a[12:7])) * MSM;
  endfunction

  task automatic model_edge(input bit tg, input bit cl, input bit ld, input bit inc,
                            input bit dec, output exp_t e);
    bit pend, dn_ev, wr, al;
    int ns;
    pend = m_tick; m_tick = 0; dn_ev = 0; wr = 0; al = 0;
    if (cl) begin
      m_total = 0; m_cnt = 0; m_state = S_IDLE;
    end else if (ld) begin
      m_total = clamp_total(ld_v); m_cnt = 0; m_state = S_IDLE;
    end else begin
      ns = m_state;
      if (tg) ns = (m_state == S_IDLE) ? S_RUN : S_IDLE;
      if (m_state == S_RUN) begin
        m_cnt = (m_cnt + 1) % DIV;
        if (m_cnt == 0) m_tick = 1;
      end
      if (inc || dec) begin
        if (inc != dec) m_total = set_field(m_total, sel_v, inc);
      end else if (pend && m_state == S_RUN) begin
        if (mode_v && stop_v && m_total == 0) begin
          ns = S_DONE; dn_ev = 1;
        end else begin
          if (!mode_v) begin
            m_total = (m_total + 1) % TOTAL;
            wr = (m_total == 0);
          end else begin
            wr = (m_total == 0);
            m_total = (m_total + TOTAL - 1) % TOTAL;
            if (stop_v && m_total == 0) begin ns = S_DONE; dn_ev = 1; end
          end
          al = aen_v && (m_total == alarm_total(atime_v));
        end
      end
      m_state = ns;
    end
    e.t = pack(m_total); e.run = (m_state == S_RUN);
    e.done = dn_ev; e.alarm = al; e.wrap = wr;
  endtask

  task automatic cyc(input bit tg = 0, input bit cl = 0, input bit ld = 0,
                     input bit inc = 0, input bit dec = 0);
    exp_t e;
    @(negedge clk);
    i_run_toggle = tg; i_clear = cl; i_load = ld; i_set_inc = inc; i_set_dec = dec;
    i_load_data = ld_v; i_field_sel = sel_v; i_mode = mode_v; i_stop_at_zero = stop_v;
    i_alarm_en = aen_v; i_alarm_time = atime_v;
    model_edge(tg, cl, ld, inc, dec, e);
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: one expected record per clocked cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({o_time, o_running, o_done, o_alarm, o_wrap} !== e) begin
          miscompares++;
          $display("FAIL scoreboard t=%0t: time=%h run=%b done=%b alarm=%b wrap=%b, expected time=%h run=%b done=%b alarm=%b wrap=%b",
                   $time, o_time, o_running, o_done, o_alarm, o_wrap,
                   e.t, e.run, e.done, e.alarm, e.wrap);
        end
        n_wrap  += int'(o_wrap);
        n_done  += int'(o_done);
        n_alarm += int'(o_alarm);
      end
    end
  end

  initial begin
    int r;
    // Reset state
    #12;
    check("reset_time", o_time, 24'd0);
    check("reset_pulses", {o_running, o_done, o_alarm, o_wrap}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Free run 100 cycles from zero: 9 msec steps
    cyc(.tg(1));
    repeat (100) cyc();
    settle();
    check("run100_time", o_time, 24'd9);
    check("run100_running", o_running, 1);
    check("run100_no_done_alarm", {o_done, o_alarm}, 2'b00);
    cyc(.tg(1));

    // Full cascade wrap 23:59:59.99 -> 0
    ld_v = {5'd23, 6'd59, 6'd59, 7'd99};
    mode_v = 0;
    cyc(.ld(1));
    n_wrap = 0;
    cyc(.tg(1));
    repeat (12) cyc();
    settle();
    check("wrap_time", o_time, 24'd0);
    check("wrap_count", n_wrap, 1);
    cyc(.tg(1));

    // Timer countdown to zero and DONE
    ld_v = 24'd2;
    cyc(.ld(1));
    mode_v = 1; stop_v = 1; n_done = 0;
    cyc(.tg(1));
    repeat (75) cyc();
    settle();
    check("timer_time", o_time, 24'd0);
    check("timer_done_count", n_done, 1);
    check("timer_not_running", o_running, 0);
    cyc(.tg(1));
    cyc(.tg(1));
    settle();
    check("done_toggle_idle_then_run", o_running, 1);
    cyc(.tg(1));

    // Load clamp, field set without carry, inc+dec cancel
    mode_v = 0; stop_v = 0;
    ld_v = {5'd31, 6'd63, 6'd63, 7'd127};
    cyc(.ld(1));
    settle();
    check("clamp", o_time, {5'd23, 6'd59, 6'd59, 7'd99});
    sel_v = 2'd2;
    cyc(.inc(1));
    settle();
    check("set_min_nocarry", o_time, {5'd23, 6'd0, 6'd59, 7'd99});
    cyc(.inc(1), .dec(1));
    settle();
    check("inc_dec_cancel", o_time, {5'd23, 6'd0, 6'd59, 7'd99});

    // Alarm at 00:00:01 from zero, then load of the same value
    cyc(.cl(1));
    atime_v = {5'd0, 6'd0, 6'd1, 7'd55};
    aen_v = 1; n_alarm = 0;
    cyc(.tg(1));
    repeat (1050) cyc();
    settle();
    check("alarm_count", n_alarm, 1);
    cyc(.tg(1));
    n_alarm = 0;
    ld_v = {5'd0, 6'd0, 6'd1, 7'd0};
    cyc(.ld(1));
    repeat (5) cyc();
    settle();
    check("alarm_not_from_load", n_alarm, 0);
    aen_v = 0;

    // Clear + load + set + toggle on a tick edge: clear wins
    cyc(.tg(1));
    repeat (20) cyc();
    ld_v = {5'd5, 6'd5, 6'd5, 7'd5};
    cyc(.tg(1), .cl(1), .ld(1), .inc(1));
    settle();
    check("clear_wins_time", o_time, 24'd0);
    check("clear_wins_idle", o_running, 0);

    // Randomized traffic
    aen_v = 1;
    for (int k = 0; k < 3000; k++) begin
      bit tg, cl, ld, inc, dec;
      tg = 0; cl = 0; ld = 0; inc = 0; dec = 0;
      if ($urandom_range(0, 199) == 0) mode_v = ~mode_v;
      if ($urandom_range(0, 199) == 0) stop_v = ~stop_v;
      if ($urandom_range(0, 299) == 0)
        atime_v = {5'($urandom_range(0, 1)), 6'($urandom_range(0, 1)),
                   6'($urandom_range(0, 3)), 7'($urandom_range(0, 127))};
      r = int'($urandom_range(0, 999));
      if (r < 25) tg = 1;
      else if (r < 28) cl = 1;
      else if (r < 38) begin
        ld = 1;
        if ($urandom_range(0, 1) == 0)
          ld_v = {5'($urandom_range(0, 1)), 6'($urandom_range(0, 1)),
                  6'($urandom_range(0, 1)), 7'($urandom_range(0, 4))};
        else
          ld_v = 24'($urandom());
      end else if (r < 58) begin
        inc = ($urandom_range(0, 1) == 1);
        dec = ($urandom_range(0, 2) != 0);
        sel_v = 2'($urandom_range(0, 3));
      end
      cyc(tg, cl, ld, inc, dec);
    end

    // Async reset mid-run
    aen_v = 0; mode_v = 0; stop_v = 0;
    ld_v = {5'd1, 6'd2, 6'd3, 7'd4};
    cyc(.ld(1));
    cyc(.tg(1));
    repeat (15) cyc();
    settle();
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_time", o_time, 24'd0);
    check("async_reset_flags", {o_running, o_done, o_alarm, o_wrap}, 4'b0000);
    exp_q.delete();
    m_total = 0; m_state = S_IDLE; m_cnt = 0; m_tick = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) cyc();
    settle();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected records left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
